// File: rtl/cgra_host_sequencer_pkg.sv
// Shared parameters, opcodes, field offsets and bus payload types for the host sequencer.
package cgra_host_sequencer_pkg;

  localparam int unsigned NUM_BUF = 4;
  localparam int unsigned CFG_W   = 203;
  localparam int unsigned SPM_W   = 20;
  localparam int unsigned A_W     = 10;
  localparam int unsigned D_W     = 32;
  localparam int unsigned LEN_W   = 16;

  localparam int unsigned IDX_W   = $clog2(NUM_BUF + 1);
  localparam int unsigned OP_W    = 3;
  localparam int unsigned HC_W    = SPM_W + NUM_BUF * CFG_W;
  localparam int unsigned EX_W    = 2 + A_W + D_W;

  // ex_bus = {ex_wen, ex_ren, ex_addr, ex_data}
  localparam int unsigned EX_DATA_LSB = 0;
  localparam int unsigned EX_ADDR_LSB = D_W;
  localparam int unsigned EX_REN_BIT  = D_W + A_W;
  localparam int unsigned EX_WEN_BIT  = D_W + A_W + 1;

  // host_controller = {scr, buf[NUM_BUF-1], ..., buf[0]}
  localparam int unsigned HC_BUF_LSB  = 0;
  localparam int unsigned HC_SCR_LSB  = NUM_BUF * CFG_W;

  localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
  localparam logic [OP_W-1:0] OP_CFG     = 3'd1;
  localparam logic [OP_W-1:0] OP_EXBURST = 3'd2;
  localparam logic [OP_W-1:0] OP_RUN     = 3'd3;
  localparam logic [OP_W-1:0] OP_WAIT    = 3'd4;
  localparam logic [OP_W-1:0] OP_END     = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_RUNGAP = 2'd2,
    ST_WAITC  = 2'd3
  } state_e;

  typedef struct packed {
    logic             wen;
    logic             ren;
    logic [A_W-1:0]   addr;
    logic [D_W-1:0]   data;
  } ex_bus_t;

  // Opcodes that take a cycle-count argument and so load the shared counter.
  function automatic logic is_count_op(input logic [OP_W-1:0] op);
    return (op == OP_EXBURST) || (op == OP_RUN) || (op == OP_WAIT);
  endfunction

endpackage

// File: rtl/cgra_host_sequencer_if.sv
// Command stream handshake between the host and the sequencer.
interface cgra_host_sequencer_if;

  logic                                             cmd_valid;
  logic                                             cmd_ready;
  logic [cgra_host_sequencer_pkg::OP_W-1:0]         cmd_op;
  logic [cgra_host_sequencer_pkg::IDX_W-1:0]        cmd_idx;
  logic [cgra_host_sequencer_pkg::A_W-1:0]          cmd_addr;
  logic [cgra_host_sequencer_pkg::CFG_W-1:0]        cmd_data;
  logic [cgra_host_sequencer_pkg::LEN_W-1:0]        cmd_len;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_addr, cmd_data, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_addr, cmd_data, cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/cgra_host_sequencer_seq_countdown.sv
// Loadable down-counter shared by the BURST, RUNGAP and WAITC states.
module cgra_host_sequencer_seq_countdown
  import cgra_host_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [LEN_W-1:0] count;

  // Load wins over decrement; the count saturates at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LEN_W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == LEN_W'(1));

endmodule

// File: rtl/cgra_host_sequencer.sv
// Command-driven host sequencer: config buffers, SPM word, init/run control and ex-bus bursts.
module cgra_host_sequencer
  import cgra_host_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  cgra_host_sequencer_if.slave   cmd,
  output logic [HC_W-1:0]        host_controller,
  output logic                   init,
  output logic                   run,
  output logic [EX_W-1:0]        ex_bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_e           state;
  logic [CFG_W-1:0] cfg_buf [NUM_BUF];
  logic [SPM_W-1:0] scr;
  ex_bus_t          ex_q;

  logic accept;
  logic cfg_we;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic cnt_last;

  // Commands are only taken in IDLE, so ready depends on state alone.
  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cfg_we        = accept && (cmd.cmd_op == OP_CFG);
  assign cnt_load      = accept && is_count_op(cmd.cmd_op);
  assign cnt_dec       = (state != ST_IDLE);

  cgra_host_sequencer_seq_countdown u_countdown (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cmd.cmd_len),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // One register per config buffer, written by a CFG aimed at its index.
  for (genvar g = 0; g < NUM_BUF; g++) begin : g_buf
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cfg_buf[g] <= '0;
      end else if (cfg_we && (cmd.cmd_idx == IDX_W'(g))) begin
        cfg_buf[g] <= cmd.cmd_data;
      end
    end
    assign host_controller[HC_BUF_LSB + g*CFG_W +: CFG_W] = cfg_buf[g];
  end

  // SPM/BG config word sits just past the last buffer index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scr <= '0;
    end else if (cfg_we && (cmd.cmd_idx == IDX_W'(NUM_BUF))) begin
      scr <= cmd.cmd_data[SPM_W-1:0];
    end
  end

  assign host_controller[HC_SCR_LSB +: SPM_W] = scr;

  // Sequencer FSM with its registered control outputs and burst address/data generator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      init  <= 1'b0;
      run   <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ex_q  <= '0;
    end else begin
      run  <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd.cmd_op)
              OP_NOP: begin
              end
              OP_CFG: begin
                init <= 1'b1;
                if (cmd.cmd_idx > IDX_W'(NUM_BUF)) begin
                  err <= 1'b1;
                end
              end
              OP_EXBURST: begin
                init <= 1'b0;
                if (cmd.cmd_len != '0) begin
                  state     <= ST_BURST;
                  ex_q.wen  <= 1'b1;
                  ex_q.addr <= cmd.cmd_addr;
                  ex_q.data <= cmd.cmd_data[D_W-1:0];
                end
              end
              OP_RUN: begin
                init  <= 1'b0;
                run   <= 1'b1;
                state <= ST_RUNGAP;
              end
              OP_WAIT: begin
                init <= 1'b0;
                if (cmd.cmd_len != '0) begin
                  state <= ST_WAITC;
                end
              end
              OP_END: begin
                init <= 1'b0;
                done <= 1'b1;
              end
              default: begin
                err <= 1'b1;
              end
            endcase
          end
        end
        ST_BURST: begin
          // Last beat is on the bus now; drop the strobe but keep addr/data.
          if (cnt_last) begin
            ex_q.wen <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            ex_q.addr <= ex_q.addr + A_W'(1);
            ex_q.data <= ex_q.data + D_W'(1);
          end
        end
        ST_RUNGAP: begin
          // First RUNGAP cycle carries the pulse, then len idle cycles.
          if (cnt_zero) begin
            state <= ST_IDLE;
          end
        end
        ST_WAITC: begin
          if (cnt_last) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ex_bus = ex_q;
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_cgra_host_sequencer.sv
// Self-checking bench for cgra_host_sequencer: directed plan plus randomized commands.
module tb_cgra_host_sequencer;
  import cgra_host_sequencer_pkg::*;

  logic             clk;
  logic             rst;
  logic [HC_W-1:0]  host_controller;
  logic             init;
  logic             run;
  logic [EX_W-1:0]  ex_bus;
  logic             busy;
  logic             done;
  logic             err;

  cgra_host_sequencer_if cmd_if ();

  cgra_host_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cmd             (cmd_if),
    .host_controller (host_controller),
    .init            (init),
    .run             (run),
    .ex_bus          (ex_bus),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model of the configuration state
  logic [CFG_W-1:0] m_buf [NUM_BUF];
  logic [SPM_W-1:0] m_scr;

  // Run-pulse monitor
  int cyc = 0;
  int run_times[$];
  int overlap = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (run === 1'b1) run_times.push_back(cyc);
    if (run === 1'b1 && init === 1'b1) overlap <= overlap + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [HC_W-1:0] hc_model();
    logic [HC_W-1:0] h;
    h = '0;
    for (int i = 0; i < int'(NUM_BUF); i++) h[i*CFG_W +: CFG_W] = m_buf[i];
    h[HC_SCR_LSB +: SPM_W] = m_scr;
    return h;
  endfunction

  function automatic logic [CFG_W-1:0] rand_cfg();
    logic [CFG_W-1:0] d;
    d = '0;
    for (int i = 0; i < 7; i++) d = {d[CFG_W-33:0], 32'($urandom())};
    return d;
  endfunction

  function automatic logic             ex_wen();  return ex_bus[EX_WEN_BIT]; endfunction
  function automatic logic             ex_ren();  return ex_bus[EX_REN_BIT]; endfunction
  function automatic logic [A_W-1:0]   ex_addr(); return ex_bus[EX_ADDR_LSB +: A_W]; endfunction
  function automatic logic [D_W-1:0]   ex_data(); return ex_bus[EX_DATA_LSB +: D_W]; endfunction

  // Waits (bounded) for ready, presents one command for exactly one accepting edge.
  task automatic send(input logic [OP_W-1:0] op, input int idx, input logic [A_W-1:0] addr,
                      input logic [CFG_W-1:0] data, input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready op=%0d: cmd_ready=%b required 1 within 300 cycles", op, cmd_if.cmd_ready);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_idx   = IDX_W'(idx);
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_len   = len;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_idx   = '0;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_len   = '0;
    for (int i = 0; i < int'(NUM_BUF); i++) m_buf[i] = '0;
    m_scr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (host_controller !== '0) begin
      errors++; $display("FAIL reset_hc: got %h required 0", host_controller);
    end
    checks++;
    if (ex_bus !== '0) begin
      errors++; $display("FAIL reset_ex_bus: got %h required 0", ex_bus);
    end
    checks++;
    if ({init, run, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: init/run/busy/done/err=%b required 00000", {init, run, busy, done, err});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", cmd_if.cmd_ready);
    end
  endtask

  task automatic test_config();
    logic [CFG_W-1:0] vals [NUM_BUF];
    logic [CFG_W-1:0] d;
    int idx;
    vals[0] = CFG_W'(48'h004708078d9f);
    vals[1] = CFG_W'(48'h00000700002f);
    vals[2] = CFG_W'(48'h07074807883f);
    vals[3] = CFG_W'(48'h07700807054f);
    for (int i = 0; i < int'(NUM_BUF); i++) begin
      send(OP_CFG, i, '0, vals[i], '0);
      m_buf[i] = vals[i];
      checks++;
      if (host_controller[i*CFG_W +: CFG_W] !== vals[i]) begin
        errors++; $display("FAIL cfg_buf%0d: got %h required %h", i, host_controller[i*CFG_W +: CFG_W], vals[i]);
      end
      checks++;
      if (init !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL cfg_init%0d: init=%b busy=%b required init=1 busy=0", i, init, busy);
      end
    end
    send(OP_CFG, NUM_BUF, '0, CFG_W'(20'h00F31), '0);
    m_scr = 20'h00F31;
    checks++;
    if (host_controller[HC_SCR_LSB +: SPM_W] !== 20'h00F31) begin
      errors++; $display("FAIL cfg_scr: got %h required 00f31", host_controller[HC_SCR_LSB +: SPM_W]);
    end
    checks++;
    if (host_controller !== hc_model()) begin
      errors++; $display("FAIL cfg_full: got %h required %h", host_controller, hc_model());
    end
    // Random CFG traffic, one command per cycle
    for (int k = 0; k < 10; k++) begin
      idx = int'($urandom_range(0, NUM_BUF));
      d = rand_cfg();
      send(OP_CFG, idx, '0, d, '0);
      if (idx < int'(NUM_BUF)) m_buf[idx] = d;
      else m_scr = d[SPM_W-1:0];
      checks++;
      if (host_controller !== hc_model()) begin
        errors++; $display("FAIL cfg_rand%0d idx=%0d: got %h required %h", k, idx, host_controller, hc_model());
      end
    end
  endtask

  task automatic test_errors();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b required 0", err);
    end
    send(OP_CFG, 5, '0, rand_cfg(), '0);
    checks++;
    if (err !== 1'b1 || init !== 1'b1) begin
      errors++; $display("FAIL err_cfg_idx: err=%b init=%b required err=1 init=1", err, init);
    end
    checks++;
    if (host_controller !== hc_model()) begin
      errors++; $display("FAIL err_cfg_nowrite: got %h required %h", host_controller, hc_model());
    end
    send(3'd7, 0, '0, rand_cfg(), 16'd9);
    checks++;
    if (err !== 1'b1 || init !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_op7: err=%b init=%b busy=%b required 1 1 0", err, init, busy);
    end
    send(3'd6, 1, '0, rand_cfg(), '0);
    checks++;
    if (host_controller !== hc_model() || cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL err_op6: ready=%b hc=%h required ready=1 hc=%h", cmd_if.cmd_ready, host_controller, hc_model());
    end
    send(OP_END, 0, '0, '0, '0);
    checks++;
    if (done !== 1'b1 || init !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL end_pulse: done=%b init=%b err=%b required 1 0 1", done, init, err);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL end_once: done=%b err=%b required 0 1", done, err);
    end
    checks++;
    if (host_controller !== hc_model()) begin
      errors++; $display("FAIL end_retain: got %h required %h", host_controller, hc_model());
    end
  endtask

  task automatic test_burst();
    logic [A_W-1:0]   base;
    logic [CFG_W-1:0] d;
    logic [D_W-1:0]   seed;
    logic [A_W-1:0]   ea;
    logic [D_W-1:0]   ed;
    int len;
    d = rand_cfg();
    send(OP_CFG, 2, '0, d, '0);
    m_buf[2] = d;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin
        base = '0; d = CFG_W'(1); len = 100;
      end else begin
        base = A_W'($urandom()); d = rand_cfg(); len = int'($urandom_range(1, 24));
      end
      seed = d[D_W-1:0];
      send(OP_EXBURST, 0, base, d, LEN_W'(len));
      if (t == 0) begin
        checks++;
        if (init !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL burst_start: init=%b busy=%b required 0 1", init, busy);
        end
      end
      for (int i = 0; i < len; i++) begin
        ea = A_W'((int'(base) + i) % 1024);
        ed = D_W'(longint'(seed) + longint'(i));
        checks++;
        if (ex_wen() !== 1'b1 || ex_ren() !== 1'b0 || ex_addr() !== ea || ex_data() !== ed) begin
          errors++;
          $display("FAIL burst%0d_beat%0d: wen=%b ren=%b addr=%0d data=%h required 1 0 %0d %h",
                   t, i, ex_wen(), ex_ren(), ex_addr(), ex_data(), ea, ed);
        end
        @(posedge clk); #1;
      end
      ea = A_W'((int'(base) + len - 1) % 1024);
      ed = D_W'(longint'(seed) + longint'(len - 1));
      checks++;
      if (ex_wen() !== 1'b0 || ex_addr() !== ea || ex_data() !== ed || busy !== 1'b0) begin
        errors++;
        $display("FAIL burst%0d_end: wen=%b addr=%0d data=%h busy=%b required 0 %0d %h 0",
                 t, ex_wen(), ex_addr(), ex_data(), busy, ea, ed);
      end
    end
    checks++;
    if (host_controller !== hc_model()) begin
      errors++; $display("FAIL burst_cfg_kept: got %h required %h", host_controller, hc_model());
    end
    send(OP_EXBURST, 0, 10'd5, CFG_W'(7), '0);
    checks++;
    if (ex_wen() !== 1'b0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL burst_len0: wen=%b busy=%b ready=%b required 0 0 1", ex_wen(), busy, cmd_if.cmd_ready);
    end
  endtask

  task automatic test_wrap();
    logic [A_W-1:0] ea [3];
    logic [D_W-1:0] ed [3];
    ea[0] = 10'd1022; ea[1] = 10'd1023; ea[2] = 10'd0;
    ed[0] = 32'hFFFFFFFF; ed[1] = 32'h0; ed[2] = 32'h1;
    send(OP_EXBURST, 0, 10'd1022, CFG_W'(32'hFFFFFFFF), 16'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ex_wen() !== 1'b1 || ex_addr() !== ea[i] || ex_data() !== ed[i]) begin
        errors++;
        $display("FAIL wrap_beat%0d: wen=%b addr=%0d data=%h required 1 %0d %h", i, ex_wen(), ex_addr(), ex_data(), ea[i], ed[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ex_wen() !== 1'b0 || ex_addr() !== 10'd0 || ex_data() !== 32'h1) begin
      errors++; $display("FAIL wrap_end: wen=%b addr=%0d data=%h required 0 0 1", ex_wen(), ex_addr(), ex_data());
    end
  endtask

  task automatic test_run_schedule();
    int lens[$];
    lens = '{0, 3, 13};
    for (int k = 0; k < 6; k++) lens.push_back(int'($urandom_range(0, 10)));
    send(OP_CFG, 1, '0, m_buf[1], '0);
    run_times.delete();
    overlap = 0;
    foreach (lens[k]) begin
      send(OP_RUN, 0, '0, '0, LEN_W'(lens[k]));
      if (k == 0) begin
        checks++;
        if (run !== 1'b1 || init !== 1'b0) begin
          errors++; $display("FAIL run_first: run=%b init=%b required 1 0", run, init);
        end
      end
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (run_times.size() != lens.size()) begin
      errors++; $display("FAIL run_count: got %0d pulse cycles required %0d", run_times.size(), lens.size());
    end else begin
      for (int k = 1; k < lens.size(); k++) begin
        checks++;
        if (run_times[k] - run_times[k-1] != lens[k-1] + 2) begin
          errors++;
          $display("FAIL run_spacing%0d: got %0d cycles required %0d", k, run_times[k] - run_times[k-1], lens[k-1] + 2);
        end
      end
    end
    checks++;
    if (overlap != 0 || run !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL run_tail: overlap=%0d run=%b busy=%b required 0 0 0", overlap, run, busy);
    end
  endtask

  task automatic test_wait();
    int lens[4];
    int n;
    send(OP_WAIT, 0, '0, '0, '0);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL wait_len0: ready=%b busy=%b required 1 0", cmd_if.cmd_ready, busy);
    end
    lens[0] = 5;
    for (int k = 1; k < 4; k++) lens[k] = int'($urandom_range(1, 20));
    for (int k = 0; k < 4; k++) begin
      send(OP_WAIT, 0, '0, '0, LEN_W'(lens[k]));
      n = 0;
      while (cmd_if.cmd_ready !== 1'b1 && n < lens[k] + 50) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n != lens[k]) begin
        errors++; $display("FAIL wait%0d: busy cycles=%0d required %0d", k, n, lens[k]);
      end
    end
  endtask

  task automatic test_reset_midburst();
    send(OP_EXBURST, 0, '0, CFG_W'(1), 16'd100);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ex_wen() !== 1'b1 || ex_addr() !== 10'd5 || ex_data() !== 32'd6 || err !== 1'b1) begin
      errors++; $display("FAIL midburst_pre: wen=%b addr=%0d data=%0d err=%b required 1 5 6 1", ex_wen(), ex_addr(), ex_data(), err);
    end
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < int'(NUM_BUF); i++) m_buf[i] = '0;
    m_scr = '0;
    checks++;
    if (ex_bus !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midburst_async: ex_bus=%h busy=%b err=%b required 0 0 0", ex_bus, busy, err);
    end
    checks++;
    if (host_controller !== hc_model()) begin
      errors++; $display("FAIL midburst_hc: got %h required 0", host_controller);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || ex_bus !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL midburst_release: ready=%b ex_bus=%h busy=%b required 1 0 0", cmd_if.cmd_ready, ex_bus, busy);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_errors();
    test_burst();
    test_wrap();
    test_run_schedule();
    test_wait();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
